// File: rtl/pll_lock_reset_seq_pkg.sv
// rtl/pll_lock_reset_seq_pkg.sv - shared FSM encoding and widths for the PLL lock reset sequencer
package pll_lock_reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } seq_state_t;

    localparam int RELOCK_W = 8;

endpackage

// File: rtl/pll_lock_reset_seq_sync_ff.sv
// rtl/pll_lock_reset_seq_sync_ff.sv - multi-stage single-bit synchroniser, async reset to 0
module pll_lock_reset_seq_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// rtl/pll_lock_reset_seq.sv - holds reset until PLL lock is stable, reasserts on filtered loss
module pll_lock_reset_seq
    import pll_lock_reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOSS_FILTER   = 4,
    parameter int CNT_W         = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                lock,
    output logic                rst_out,
    output logic                ready,
    output logic                lock_lost,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;

    pll_lock_reset_seq_sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clock(clock),
        .reset(reset),
        .d    (lock),
        .q    (lock_s)
    );

    // The edge that leaves WAIT_LOCK already counts as the first stable cycle,
    // so release lands exactly STABLE_CYCLES synced-high cycles after lock_s rises.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            rst_out      <= 1'b1;
            ready        <= 1'b0;
            lock_lost    <= 1'b0;
            relock_count <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    cnt <= '0;
                    if (lock_s) begin
                        if (STABLE_CYCLES == 1) begin
                            state   <= RUN;
                            rst_out <= 1'b0;
                            ready   <= 1'b1;
                        end else begin
                            state <= STABILIZE;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state   <= RUN;
                        cnt     <= '0;
                        rst_out <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (lock_s) begin
                        cnt <= '0;
                    end else if (cnt == LOSS_LAST) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        rst_out   <= 1'b1;
                        ready     <= 1'b0;
                        lock_lost <= 1'b1;
                        if (relock_count != {RELOCK_W{1'b1}}) begin
                            relock_count <= relock_count + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= WAIT_LOCK;
                    cnt     <= '0;
                    rst_out <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb/tb_pll_lock_reset_seq.sv - self-checking bench for pll_lock_reset_seq
module tb_pll_lock_reset_seq;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int LOSS   = 4;

    logic       clock;
    logic       reset;
    logic       lock;
    logic       rst_out;
    logic       ready;
    logic       lock_lost;
    logic [7:0] relock_count;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_reset_seq #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .LOSS_FILTER  (LOSS),
        .CNT_W        (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .lock        (lock),
        .rst_out     (rst_out),
        .ready       (ready),
        .lock_lost   (lock_lost),
        .relock_count(relock_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference: lock delayed SYNC edges, then run-length rules on the synced stream
    bit q[$];
    bit m_ready;
    bit m_lost;
    int m_cnt;
    int hi_run;
    int lo_run;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < SYNC; i++) q.push_back(1'b0);
        m_ready = 0;
        m_lost  = 0;
        m_cnt   = 0;
        hi_run  = 0;
        lo_run  = 0;
    endtask

    task automatic model_edge();
        bit s;
        if (reset) begin
            model_reset();
            return;
        end
        s = q.pop_front();
        q.push_back(lock);
        if (!m_ready) begin
            hi_run = s ? hi_run + 1 : 0;
            if (hi_run >= STABLE) begin
                m_ready = 1;
                lo_run  = 0;
            end
        end else begin
            lo_run = s ? 0 : lo_run + 1;
            if (lo_run >= LOSS) begin
                m_ready = 0;
                hi_run  = 0;
                m_lost  = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        check("model_rst_out", int'(rst_out), int'(!m_ready));
        check("model_ready", int'(ready), int'(m_ready));
        check("model_lock_lost", int'(lock_lost), int'(m_lost));
        check("model_relock_count", int'(relock_count), m_cnt);
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic wait_rst(input logic want, input int limit, output int edges);
        edges = -1;
        for (int k = 1; k <= limit; k++) begin
            cyc();
            if (rst_out === want) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic lock_val);
        lock  = lock_val;
        reset = 1'b1;
        model_reset();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic lock;
        int   cycles;
        logic exp_rst;
        logic exp_ready;
        logic exp_lost;
        int   exp_count;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int e;
        int val;
        int len;

        vecs[0]  = '{1'b0, 4,  1'b1, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b1, 10, 1'b0, 1'b1, 1'b0, 0};
        vecs[2]  = '{1'b0, 3,  1'b0, 1'b1, 1'b0, 0};
        vecs[3]  = '{1'b1, 8,  1'b0, 1'b1, 1'b0, 0};
        vecs[4]  = '{1'b0, 6,  1'b1, 1'b0, 1'b1, 1};
        vecs[5]  = '{1'b0, 4,  1'b1, 1'b0, 1'b1, 1};
        vecs[6]  = '{1'b1, 10, 1'b0, 1'b1, 1'b1, 1};
        vecs[7]  = '{1'b1, 5,  1'b0, 1'b1, 1'b1, 1};
        vecs[8]  = '{1'b0, 5,  1'b0, 1'b1, 1'b1, 1};
        vecs[9]  = '{1'b0, 1,  1'b1, 1'b0, 1'b1, 2};
        vecs[10] = '{1'b1, 9,  1'b1, 1'b0, 1'b1, 2};
        vecs[11] = '{1'b1, 1,  1'b0, 1'b1, 1'b1, 2};

        // Reset held 5 cycles with lock high, then exact release latency
        reset = 1'b1;
        lock  = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) cyc();
        check("reset_rst_out", int'(rst_out), 1);
        check("reset_ready", int'(ready), 0);
        check("reset_lock_lost", int'(lock_lost), 0);
        check("reset_relock_count", int'(relock_count), 0);
        reset = 1'b0;
        wait_rst(1'b0, 40, e);
        check("t1_release_latency", e, SYNC + STABLE);
        check("t1_ready_same_edge", int'(ready), 1);

        // Lock drops mid-stabilize, then full wait after the second rise
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) cyc();
        lock = 1'b1;
        for (int i = 0; i < 7; i++) cyc();
        lock = 1'b0;
        cyc();
        cyc();
        check("t2_held_in_reset", int'(rst_out), 1);
        lock = 1'b1;
        wait_rst(1'b0, 40, e);
        check("t2_release_latency", e, SYNC + STABLE);
        check("t2_relock_count", int'(relock_count), 0);

        // Real loss in RUN: exact assert latency, sticky flag, relock
        lock = 1'b0;
        wait_rst(1'b1, 20, e);
        check("t4_loss_latency", e, SYNC + LOSS);
        check("t4_lock_lost", int'(lock_lost), 1);
        check("t4_relock_count", int'(relock_count), 1);
        for (int i = 0; i < 4; i++) cyc();
        lock = 1'b1;
        wait_rst(1'b0, 40, e);
        check("t4_relock_latency", e, SYNC + STABLE);
        check("t4_lock_lost_sticky", int'(lock_lost), 1);

        // Table of lock phases with hand-derived end-of-phase outputs
        do_reset(1'b0);
        for (int v = 0; v < 12; v++) begin
            lock = vecs[v].lock;
            for (int i = 0; i < vecs[v].cycles; i++) cyc();
            check($sformatf("vec%0d_rst_out", v), int'(rst_out), int'(vecs[v].exp_rst));
            check($sformatf("vec%0d_ready", v), int'(ready), int'(vecs[v].exp_ready));
            check($sformatf("vec%0d_lock_lost", v), int'(lock_lost), int'(vecs[v].exp_lost));
            check($sformatf("vec%0d_relock_count", v), int'(relock_count), vecs[v].exp_count);
        end

        // 260 loss/relock rounds saturate the counter
        for (int r = 0; r < 260; r++) begin
            lock = 1'b0;
            for (int i = 0; i < SYNC + LOSS; i++) cyc();
            lock = 1'b1;
            for (int i = 0; i < SYNC + STABLE; i++) cyc();
            if (r == 252) check("t5_count_before_sat", int'(relock_count), 255);
        end
        check("t5_relock_saturated", int'(relock_count), 255);
        check("t5_ready_after_sat", int'(ready), 1);

        // Async reset mid-RUN clears everything without a clock edge
        reset = 1'b1;
        model_reset();
        #1;
        check("t6_run_rst_out", int'(rst_out), 1);
        check("t6_run_ready", int'(ready), 0);
        check("t6_run_lock_lost", int'(lock_lost), 0);
        check("t6_run_relock_count", int'(relock_count), 0);
        cyc();
        reset = 1'b0;
        wait_rst(1'b0, 40, e);
        check("t6_release_after_run_reset", e, SYNC + STABLE);

        // Async reset mid-STABILIZE restarts the full wait
        do_reset(1'b0);
        lock = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        reset = 1'b1;
        model_reset();
        #1;
        check("t6_stab_rst_out", int'(rst_out), 1);
        cyc();
        reset = 1'b0;
        wait_rst(1'b0, 40, e);
        check("t6_release_after_stab_reset", e, SYNC + STABLE);

        // Random lock run lengths against the reference
        do_reset(1'b0);
        val = 0;
        for (int n = 0; n < 150; n++) begin
            val  = 1 - val;
            len  = int'($urandom_range(1, 14));
            lock = val[0];
            for (int i = 0; i < len; i++) cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
